// File: rtl/inv_converter_pipe.sv
// rtl/inv_converter_pipe.sv - pipelined two's-complement conditional negator with valid/ready stream ports
// Segment k of the carry chain is resolved just ahead of register stage k; upper segments ride raw.
module inv_converter_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int SEG = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_neg;
    logic [STAGES-1:0] r_any;
    logic [WIDTH-1:0]  r_data [STAGES];

    logic              w_neg_in;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_src_v;
    logic [STAGES-1:0] w_src_neg;
    logic [STAGES-1:0] w_src_any;
    logic [STAGES-1:0] w_nxt_any;
    logic [WIDTH-1:0]  w_src_data [STAGES];
    logic [WIDTH-1:0]  w_nxt_data [STAGES];

    always_comb begin
        w_neg_in = 1'b0;
        case (in_mode)
            2'b00:   w_neg_in = 1'b0;
            2'b01:   w_neg_in = 1'b1;
            2'b10:   w_neg_in = in_data[WIDTH-1];
            default: w_neg_in = in_neg;
        endcase
    end

    // A stage may advance if it or any stage after it is empty, or the sink takes the head.
    always_comb begin
        w_adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_v[j]) w_adv[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_src_v       = '0;
        w_src_neg     = '0;
        w_src_any     = '0;
        w_src_v[0]    = in_valid;
        w_src_neg[0]  = w_neg_in;
        w_src_data[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]    = r_v[k-1];
            w_src_neg[k]  = r_neg[k-1];
            w_src_any[k]  = r_any[k-1];
            w_src_data[k] = r_data[k-1];
        end
    end

    // any_lo accumulates the original operand bits, so it is read before each bit is rewritten.
    always_comb begin
        w_nxt_any = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_data[k] = w_src_data[k];
            w_nxt_any[k]  = w_src_any[k];
            for (int b = 0; b < SEG; b++) begin
                w_nxt_data[k][k*SEG+b] = w_src_data[k][k*SEG+b] ^ (w_src_neg[k] & w_nxt_any[k]);
                w_nxt_any[k]           = w_nxt_any[k] | w_src_data[k][k*SEG+b];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_v   <= '0;
            r_neg <= '0;
            r_any <= '0;
            for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_data[k] <= w_nxt_data[k];
                        r_neg[k]  <= w_src_neg[k];
                        r_any[k]  <= w_nxt_any[k];
                    end
                end
            end
        end
    end

    // Negation only maps MIN_VAL onto itself, so the result alone identifies overflow.
    assign in_ready  = w_adv[0];
    assign out_valid = r_v[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_ovf   = r_v[STAGES-1] & r_neg[STAGES-1] & (r_data[STAGES-1] == MIN_VAL);
    assign out_zero  = r_v[STAGES-1] & ~r_any[STAGES-1];

endmodule
